// File: rtl/vga_term_pkg.sv
// Shared definitions for the text-mode terminal writer: geometry defaults,
// FSM states, control codes and character-memory word layout.
package vga_term_pkg;

   localparam int DEF_COLS = 70;
   localparam int DEF_ROWS = 30;

   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_SPACE = 8'h20;

   localparam int ADDR_ROW_LSB = 1;
   localparam int ADDR_COL_LSB = 6;
   localparam int DIN_FG_LSB   = 8;
   localparam int DIN_BG_LSB   = 11;

   typedef enum logic [1:0] {IDLE, WRITE, CLR_LINE, CLR_ALL} state_e;

   function automatic logic [31:0] mk_addr(logic [4:0] row, logic [6:0] col);
      logic [31:0] a;
      a = '0;
      a[ADDR_ROW_LSB +: 5] = row;
      a[ADDR_COL_LSB +: 7] = col;
      return a;
   endfunction

   function automatic logic [31:0] mk_din(logic [7:0] ch, logic [2:0] fg, logic [2:0] bg);
      logic [31:0] d;
      d = '0;
      d[7:0] = ch;
      d[DIN_FG_LSB +: 3] = fg;
      d[DIN_BG_LSB +: 3] = bg;
      return d;
   endfunction

   function automatic logic is_printable(logic [7:0] b);
      return (b >= 8'h20) && (b <= 8'h7E);
   endfunction

endpackage

// File: rtl/vga_term_if.sv
// Byte-input handshake plus character-memory write port of the terminal.
interface vga_term_if;
   logic        char_valid;
   logic [7:0]  char_data;
   logic        char_ready;
   logic [2:0]  fg_color;
   logic [2:0]  bg_color;
   logic        clear_req;
   logic        sel;
   logic        we;
   logic [31:0] addr;
   logic [31:0] din;

   modport slave (
      input  char_valid, char_data, fg_color, bg_color, clear_req,
      output char_ready, sel, we, addr, din
   );

   modport master (
      output char_valid, char_data, fg_color, bg_color, clear_req,
      input  char_ready, sel, we, addr, din
   );
endinterface

// File: rtl/vga_term_cursor.sv
// Cursor row/column counters with increment, backspace, carriage return,
// newline (row wraps to 0) and home controls.
module vga_term_cursor #(
   parameter int COLS = 70,
   parameter int ROWS = 30
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       inc,
   input  logic       dec,
   input  logic       cr,
   input  logic       newline,
   input  logic       home,
   output logic [4:0] row,
   output logic [6:0] col
);
   localparam logic [6:0] LAST_COL = 7'(COLS - 1);
   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         row <= '0;
         col <= '0;
      end else if (home) begin
         row <= '0;
         col <= '0;
      end else if (newline) begin
         col <= '0;
         row <= (row == LAST_ROW) ? 5'd0 : row + 5'd1;
      end else if (cr) begin
         col <= '0;
      end else if (inc) begin
         col <= (col == LAST_COL) ? 7'd0 : col + 7'd1;
      end else if (dec && col != 7'd0) begin
         col <= col - 7'd1;
      end
   end
endmodule

// File: rtl/vga_term.sv
// Text terminal: turns accepted ASCII bytes into character-memory writes,
// handling wrap, newline line-clear, CR, backspace and full-screen clear.
module vga_term
   import vga_term_pkg::*;
#(
   parameter int COLS = DEF_COLS,
   parameter int ROWS = DEF_ROWS
) (
   input  logic       clock,
   input  logic       reset,
   vga_term_if.slave  bus,
   output logic [4:0] cursor_row,
   output logic [6:0] cursor_col,
   output logic       busy
);
   localparam logic [6:0] LAST_COL = 7'(COLS - 1);
   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

   state_e      state, state_n;
   logic        clear_pend, pend_n;
   logic [2:0]  fg_q, fg_n, bg_q, bg_n;
   logic        wrap_q, wrap_n;
   logic [4:0]  clr_row, crow_n;
   logic [6:0]  clr_col, ccol_n;
   logic        sel_q, sel_n;
   logic [31:0] addr_q, addr_n, din_q, din_n;
   logic        inc, dec, cr, nl, home;

   vga_term_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
      .clock(clock), .reset(reset), .inc(inc), .dec(dec), .cr(cr),
      .newline(nl), .home(home), .row(cursor_row), .col(cursor_col)
   );

   assign bus.char_ready = (state == IDLE) && !clear_pend;
   assign bus.sel  = sel_q;
   assign bus.we   = sel_q;
   assign bus.addr = addr_q;
   assign bus.din  = din_q;
   assign busy     = (state != IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         clear_pend <= 1'b0;
         fg_q       <= '0;
         bg_q       <= '0;
         wrap_q     <= 1'b0;
         clr_row    <= '0;
         clr_col    <= '0;
         sel_q      <= 1'b0;
         addr_q     <= '0;
         din_q      <= '0;
      end else begin
         state      <= state_n;
         clear_pend <= pend_n;
         fg_q       <= fg_n;
         bg_q       <= bg_n;
         wrap_q     <= wrap_n;
         clr_row    <= crow_n;
         clr_col    <= ccol_n;
         sel_q      <= sel_n;
         addr_q     <= addr_n;
         din_q      <= din_n;
      end
   end

   always_comb begin
      state_n = state;
      pend_n  = clear_pend | bus.clear_req;
      fg_n    = fg_q;
      bg_n    = bg_q;
      wrap_n  = wrap_q;
      crow_n  = clr_row;
      ccol_n  = clr_col;
      sel_n   = 1'b0;
      addr_n  = addr_q;
      din_n   = din_q;
      inc = 1'b0; dec = 1'b0; cr = 1'b0; nl = 1'b0; home = 1'b0;
      unique case (state)
         IDLE: begin
            if (clear_pend) begin
               state_n = CLR_ALL;
               crow_n  = '0;
               ccol_n  = '0;
            end else if (bus.char_valid) begin
               fg_n   = bus.fg_color;
               bg_n   = bus.bg_color;
               wrap_n = 1'b0;
               if (is_printable(bus.char_data)) begin
                  sel_n   = 1'b1;
                  addr_n  = mk_addr(cursor_row, cursor_col);
                  din_n   = mk_din(bus.char_data, bus.fg_color, bus.bg_color);
                  state_n = WRITE;
                  // Last column: hold the cursor and let WRITE issue the newline.
                  if (cursor_col == LAST_COL) wrap_n = 1'b1;
                  else inc = 1'b1;
               end else if (bus.char_data == CH_LF) begin
                  nl      = 1'b1;
                  ccol_n  = '0;
                  state_n = CLR_LINE;
               end else if (bus.char_data == CH_CR) begin
                  cr      = 1'b1;
                  state_n = WRITE;
               end else if (bus.char_data == CH_BS && cursor_col != 7'd0) begin
                  dec     = 1'b1;
                  sel_n   = 1'b1;
                  addr_n  = mk_addr(cursor_row, cursor_col - 7'd1);
                  din_n   = mk_din(CH_SPACE, bus.fg_color, bus.bg_color);
                  state_n = WRITE;
               end
            end
         end
         WRITE: begin
            if (wrap_q) begin
               nl      = 1'b1;
               ccol_n  = '0;
               state_n = CLR_LINE;
            end else begin
               state_n = IDLE;
            end
         end
         CLR_LINE: begin
            sel_n  = 1'b1;
            addr_n = mk_addr(cursor_row, clr_col);
            din_n  = mk_din(CH_SPACE, fg_q, bg_q);
            if (clr_col == LAST_COL) state_n = IDLE;
            else ccol_n = clr_col + 7'd1;
         end
         CLR_ALL: begin
            sel_n  = 1'b1;
            addr_n = mk_addr(clr_row, clr_col);
            din_n  = mk_din(CH_SPACE, fg_q, bg_q);
            if (clr_col == LAST_COL) begin
               ccol_n = '0;
               if (clr_row == LAST_ROW) begin
                  home    = 1'b1;
                  pend_n  = bus.clear_req;
                  state_n = IDLE;
               end else begin
                  crow_n = clr_row + 5'd1;
               end
            end else begin
               ccol_n = clr_col + 7'd1;
            end
         end
      endcase
   end
endmodule

// File: tb/tb_vga_term.sv
// Scoreboard bench for vga_term: a text-screen model predicts every memory
// write; a negedge monitor pops and compares each strobe the DUT emits.
module tb_vga_term;
   localparam int COLS  = 70;
   localparam int ROWS  = 30;
   localparam int LIMIT = 6000;

   typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] cursor_row;
   logic [6:0] cursor_col;
   logic       busy;

   vga_term_if bus ();

   vga_term #(.COLS(COLS), .ROWS(ROWS)) dut (
      .clock(clock), .reset(reset), .bus(bus),
      .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
   );

   always #5 clock = ~clock;

   int vectors = 0;
   int errors  = 0;
   wr_t exp_q[$];
   int m_row = 0, m_col = 0, m_fg = 0, m_bg = 0;
   logic [31:0] last_a = '0, last_d = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic void push_wr(int r, int c, int ch);
      wr_t w;
      w.a = c * 64 + r * 2;
      w.d = ch + m_fg * 256 + m_bg * 2048;
      last_a = w.a;
      last_d = w.d;
      exp_q.push_back(w);
   endfunction

   function automatic void model_newline();
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
      for (int c = 0; c < COLS; c++) push_wr(m_row, c, 32);
   endfunction

   function automatic void model_byte(input int ch, input int fg, input int bg);
      m_fg = fg;
      m_bg = bg;
      if (ch >= 32 && ch <= 126) begin
         push_wr(m_row, m_col, ch);
         if (m_col == COLS - 1) model_newline();
         else m_col++;
      end else if (ch == 10) begin
         model_newline();
      end else if (ch == 13) begin
         m_col = 0;
      end else if (ch == 8 && m_col > 0) begin
         m_col--;
         push_wr(m_row, m_col, 32);
      end
   endfunction

   function automatic void model_clear();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) push_wr(r, c, 32);
      m_row = 0;
      m_col = 0;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clock) begin
      wr_t w;
      check("we_eq_sel", {31'd0, bus.we}, {31'd0, bus.sel});
      if (bus.sel === 1'b1) begin
         if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_strobe: addr 0x%0h din 0x%0h, no write expected at %0t",
                     bus.addr, bus.din, $time);
         end else begin
            w = exp_q.pop_front();
            check("strobe_addr", bus.addr, w.a);
            check("strobe_din", bus.din, w.d);
         end
      end
   end

   // ---------------- driver ----------------
   task automatic send(input logic [7:0] ch, input logic [2:0] fg, input logic [2:0] bg,
                       input bit pulse_clr);
      int t = 0;
      @(negedge clock);
      bus.char_valid = 1'b1;
      bus.char_data  = ch;
      bus.fg_color   = fg;
      bus.bg_color   = bg;
      if (pulse_clr) begin
         bus.clear_req = 1'b1;
         model_clear();
         @(negedge clock);
         bus.clear_req = 1'b0;
      end
      while (bus.char_ready !== 1'b1 && t < LIMIT) begin
         @(negedge clock);
         t++;
      end
      if (t >= LIMIT) begin
         vectors++;
         errors++;
         $display("FAIL ready_timeout: char_ready low for %0d cycles, expected high", t);
         bus.char_valid = 1'b0;
      end else begin
         model_byte(int'(ch), int'(fg), int'(bg));
         @(posedge clock);
         #1;
         bus.char_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int t = 0;
      do begin
         @(negedge clock);
         #1;
         t++;
      end while ((busy || exp_q.size() != 0 || bus.char_ready !== 1'b1) && t < LIMIT);
      if (t >= LIMIT) begin
         vectors++;
         errors++;
         $display("FAIL idle_timeout: busy=%0b pending=%0d after %0d cycles, expected idle",
                  busy, exp_q.size(), t);
      end
   endtask

   task automatic check_state();
      check("cursor_row", {27'd0, cursor_row}, m_row);
      check("cursor_col", {25'd0, cursor_col}, m_col);
      check("busy_idle", {31'd0, busy}, 0);
      check("addr_hold", bus.addr, last_a);
      check("din_hold", bus.din, last_d);
   endtask

   task automatic clear_screen();
      @(negedge clock);
      bus.clear_req = 1'b1;
      model_clear();
      @(negedge clock);
      bus.clear_req = 1'b0;
   endtask

   function automatic logic [7:0] rand_byte();
      int k;
      logic [7:0] b;
      k = $urandom_range(0, 99);
      if (k < 60) b = 8'($urandom_range(32, 126));
      else if (k < 68) b = 8'h0A;
      else if (k < 78) b = 8'h0D;
      else if (k < 90) b = 8'h08;
      else begin
         b = 8'($urandom_range(0, 255));
         if (b == 8'h08 || b == 8'h0A || b == 8'h0D || (b >= 8'h20 && b <= 8'h7E)) b = 8'h7F;
      end
      return b;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      bus.char_valid = 1'b0;
      bus.char_data  = '0;
      bus.fg_color   = '0;
      bus.bg_color   = '0;
      bus.clear_req  = 1'b0;

      repeat (3) @(negedge clock);
      check("rst_sel", {31'd0, bus.sel}, 0);
      check("rst_addr", bus.addr, 0);
      check("rst_din", bus.din, 0);
      check("rst_ready", {31'd0, bus.char_ready}, 1);
      #2 reset = 1'b0;
      wait_idle();
      check_state();

      // Single printable at the origin.
      send(8'h41, 3'd7, 3'd1, 1'b0);
      wait_idle();
      check("a_din_const", bus.din, 32'h0F41);
      check("a_addr_const", bus.addr, 32'h0);
      check_state();

      // Move to (3,5), write 'B', then backspace over it.
      repeat (3) send(8'h0A, 3'd0, 3'd0, 1'b0);
      send(8'h0D, 3'd0, 3'd0, 1'b0);
      repeat (5) send(8'h2E, 3'd4, 3'd4, 1'b0);
      wait_idle();
      check_state();
      send(8'h42, 3'd2, 3'd0, 1'b0);
      wait_idle();
      check("b_addr_const", bus.addr, 32'h146);
      check("b_din_const", bus.din, 32'h242);
      send(8'h08, 3'd2, 3'd0, 1'b0);
      wait_idle();
      check("bs_addr_const", bus.addr, 32'h146);
      check("bs_din_const", bus.din, 32'h220);
      check_state();

      // Backspace at column 0 is a no-op; CR at column 40 writes nothing.
      send(8'h0D, 3'd1, 3'd1, 1'b0);
      send(8'h08, 3'd1, 3'd1, 1'b0);
      repeat (40) send(8'($urandom_range(32, 126)), 3'd6, 3'd5, 1'b0);
      wait_idle();
      check_state();
      send(8'h0D, 3'd1, 3'd2, 1'b0);
      wait_idle();
      check_state();

      // Walk down to the last row, then newline wraps to row 0.
      while (m_row != ROWS - 1) send(8'h0A, 3'd5, 3'd3, 1'b0);
      wait_idle();
      check_state();
      send(8'h0A, 3'd3, 3'd6, 1'b0);
      wait_idle();
      check_state();

      // A full row of printables wraps into a line clear of row 1.
      for (int i = 0; i < COLS; i++) send(8'(33 + (i % 90)), 3'(i), 3'(i + 3), 1'b0);
      wait_idle();
      check_state();

      // Clear request arriving during a line clear with a byte held.
      send(8'h0A, 3'd3, 3'd4, 1'b0);
      send(8'h5A, 3'd5, 3'd2, 1'b1);
      wait_idle();
      check_state();

      // Randomized traffic, back-to-back where the DUT allows.
      for (int i = 0; i < 160; i++) begin
         send(rand_byte(), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0);
         if (i % 20 == 19) begin
            wait_idle();
            check_state();
         end
         if (i == 90) begin
            wait_idle();
            clear_screen();
            wait_idle();
            check_state();
         end
      end

      // Reset in the middle of a full-screen clear.
      wait_idle();
      clear_screen();
      repeat (100) @(negedge clock);
      check("midclr_sel", {31'd0, bus.sel}, 1);
      #2 reset = 1'b1;
      #1;
      check("rst_async_sel", {31'd0, bus.sel}, 0);
      check("rst_async_we", {31'd0, bus.we}, 0);
      check("rst_async_addr", bus.addr, 0);
      check("rst_async_din", bus.din, 0);
      exp_q.delete();
      m_row = 0; m_col = 0; m_fg = 0; m_bg = 0;
      last_a = '0; last_d = '0;
      repeat (5) @(negedge clock);
      #2 reset = 1'b0;
      repeat (30) @(negedge clock);
      #1;
      check_state();
      check("post_rst_ready", {31'd0, bus.char_ready}, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/vga_term.md
VGA_TERM -- requirements
Module: vga_term

Interface
REQ-001 SHALL have parameter COLS, default 70: text columns, col 0..COLS-1; 70*9 px = 630 px.
REQ-002 SHALL have parameter ROWS, default 30: text rows, row 0..ROWS-1; 30*16 px = 480 px.
REQ-003 clock  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 char_valid  input  1  byte offered on char_data.
REQ-006 char_data  input  8  ASCII byte.
REQ-007 char_ready  output  1  byte accepted when char_valid&&char_ready at a rising edge.
REQ-008 fg_color  input  3  foreground colour, latched at acceptance.
REQ-009 bg_color  input  3  background colour, latched at acceptance.
REQ-010 clear_req  input  1  single-cycle pulse requesting a full-screen clear.
REQ-011 sel  output  1  character-memory select.
REQ-012 we  output  1  character-memory write enable; always equal to sel.
REQ-013 addr  output  32  write address: col in [12:6], row in [5:1], all other bits 0.
REQ-014 din  output  32  write data: ascii [7:0], fg [10:8], bg [13:11], [31:14]=0.
REQ-015 cursor_row  output  5  current row.
REQ-016 cursor_col  output  7  current column.
REQ-017 busy  output  1  high whenever state != IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, WRITE, CLR_LINE and CLR_ALL; sel, we, addr and din SHALL be registered.
REQ-019 char_ready SHALL equal (state==IDLE && !clear_pend).
REQ-020 A clear_req pulse SHALL set clear_pend in any state; IDLE with clear_pend SHALL enter CLR_ALL, with priority over a simultaneous char_valid.
REQ-021 A printable byte (0x20-0x7E) accepted at edge N SHALL produce exactly one strobe (sel=we=1) in cycle N+1 at the cursor, then col+1, then IDLE.
REQ-022 A printable byte written at col COLS-1 SHALL be followed by a newline action (REQ-023) starting in cycle N+2.
REQ-023 Newline (0x0A, or wrap per REQ-022) SHALL set col=0, set row=row+1 (ROWS-1 wraps to 0), then enter CLR_LINE.
REQ-024 CLR_LINE SHALL write space (0x20) with latched colours to cols 0..COLS-1 of the new row, one strobe per cycle on consecutive cycles, then return to IDLE.
REQ-025 Carriage return (0x0D) SHALL set col=0 with no write; char_ready SHALL be high again at N+2.
REQ-026 Backspace (0x08) with col>0 SHALL decrement col and write a space there in N+1; with col=0 it SHALL perform no write and no cursor change.
REQ-027 All other bytes SHALL be accepted and discarded with no write.
REQ-028 CLR_ALL SHALL write a space to every cell, row-major from (0,0), ROWS*COLS consecutive strobes, then set cursor (0,0), clear clear_pend and return to IDLE.
REQ-029 Outside strobe cycles, sel and we SHALL be 0; addr and din SHALL hold their last values.

Reset
REQ-030 Reset SHALL force state=IDLE, cursor (0,0), sel=we=0, addr=din=0 and clear_pend=0, asynchronously; an in-progress operation is abandoned and the screen is not auto-cleared.

Structure
REQ-031 Package vga_term_pkg SHALL hold COLS/ROWS defaults, the state enum, control-code constants (0x08, 0x0A, 0x0D, 0x20) and addr/din field positions.
REQ-032 Sub-module vga_term_cursor SHALL hold the row/col counters, with inc/dec/cr/newline/home controls and wrap logic.

Verification
REQ-033 After reset, send 0x41 with fg=7, bg=1 -> one strobe, addr=0x0, din=0x0F41, cursor (0,1).
REQ-034 At cursor (3,5), send 0x42 with fg=2, bg=0 -> addr=0x146, din=0x0242; a 0x08 then writes a space at addr=0x146 and leaves cursor (3,5).
REQ-035 From (0,0), send 70 printable bytes -> 70 writes to row 0, then 70 space writes (addr=col<<6|0x2), final cursor (1,0), busy low afterwards.
REQ-036 At row 29, send 0x0A -> 70 space writes to row 0 and cursor (0,0); 0x0D at col 40 -> no strobe and col=0.
REQ-037 Pulse clear_req during CLR_LINE while char_valid is held -> the line clear completes, then 2100 CLR_ALL strobes, then the held byte is accepted at (0,0).
REQ-038 Assert reset mid-CLR_ALL -> sel/we drop in the same cycle and outputs hold their reset values with no further strobes.
